// File: rtl/pc_redirect_arb_if.sv
// Bundles the decode, hazard and exception signals that steer the fetch PC.
// The master side drives the requests and the slave side (the arbiter)
// returns the PC source selection.
interface pc_redirect_arb_if;
  logic        eret;
  logic [31:0] epc;
  logic        int_req;
  logic        pause;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jr_valid;
  logic        jr_wait;
  logic [31:0] jr_target;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [31:0] redir_pc;
  logic        flush_fd;
  logic        in_handler;
  logic        pend_valid;

  modport master (
    output eret, epc, int_req, pause, br_taken, br_target,
           jr_valid, jr_wait, jr_target,
    input  pc_we, pc_sel, redir_pc, flush_fd, in_handler, pend_valid
  );

  modport slave (
    input  eret, epc, int_req, pause, br_taken, br_target,
           jr_valid, jr_wait, jr_target,
    output pc_we, pc_sel, redir_pc, flush_fd, in_handler, pend_valid
  );
endinterface

// File: rtl/pc_redirect_arb.sv
// PC redirect arbiter: picks the next-PC source each cycle from exception
// return, interrupt, stall, jr and branch requests. A redirect that shows up
// while the pipe is stalled is parked in a one-entry buffer (first wins) and
// replayed on the cycle the stall lifts. A jr whose source register is not
// yet forwardable holds the PC in the JRW state until the value arrives.
module pc_redirect_arb #(
  parameter logic [31:0] EXC_VEC = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  pc_redirect_arb_if.slave  bus
);

  // The interrupt entry address is applied by the PC mux outside this block;
  // reject an entry point that could never be fetched.
  if (EXC_VEC[1:0] != 2'b00) begin : gBadExcVec
    $error("pc_redirect_arb: EXC_VEC must be word aligned");
  end

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    JRW  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic        pendValid_q, pendValid_d;
  logic        inHandler_q, inHandler_d;

  logic        pcWe;
  logic [1:0]  pcSel;
  logic [31:0] redirPc;
  logic        flushFd;

  logic        newRedir;
  logic [31:0] newTarget;

  // Decode-stage redirect candidate: a jr in decode owns the slot, and only
  // counts once its register value is forwardable; otherwise a taken branch.
  always_comb begin
    newRedir  = 1'b0;
    newTarget = 32'h0;
    if (bus.jr_valid) begin
      newRedir  = !bus.jr_wait;
      newTarget = bus.jr_target;
    end else if (bus.br_taken) begin
      newRedir  = 1'b1;
      newTarget = bus.br_target;
    end
  end

  // Priority arbitration: eret, interrupt, stall, buffered/jr-wait replay,
  // then the normal run-time jr/branch/sequential choice.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pendValid_d = pendValid_q;
    inHandler_d = inHandler_q;
    pcWe        = 1'b0;
    pcSel       = 2'b00;
    redirPc     = 32'h0;
    flushFd     = 1'b0;

    if (bus.eret) begin
      pcWe        = 1'b1;
      pcSel       = 2'b11;
      flushFd     = 1'b1;
      inHandler_d = 1'b0;
      pendValid_d = 1'b0;
      pend_d      = 32'h0;
      state_d     = RUN;
    end else if (bus.int_req && !inHandler_q) begin
      pcWe        = 1'b1;
      pcSel       = 2'b10;
      flushFd     = 1'b1;
      inHandler_d = 1'b1;
      pendValid_d = 1'b0;
      pend_d      = 32'h0;
      state_d     = RUN;
    end else if (bus.pause) begin
      // A waiting jr keeps its JRW identity through the stall.
      if (state_q != JRW) begin
        state_d = HOLD;
      end
      if (newRedir && !pendValid_q) begin
        pend_d      = newTarget;
        pendValid_d = 1'b1;
      end
    end else if (pendValid_q) begin
      pcWe        = 1'b1;
      pcSel       = 2'b01;
      redirPc     = pend_q;
      flushFd     = 1'b1;
      pendValid_d = 1'b0;
      pend_d      = 32'h0;
      state_d     = RUN;
    end else if (state_q == JRW) begin
      if (!bus.jr_wait) begin
        pcWe    = 1'b1;
        pcSel   = 2'b01;
        redirPc = bus.jr_target;
        flushFd = 1'b1;
        state_d = RUN;
      end
    end else begin
      // RUN, or HOLD whose stall just lifted with nothing buffered.
      state_d = RUN;
      if (bus.jr_valid && bus.jr_wait) begin
        state_d = JRW;
      end else if (newRedir) begin
        pcWe    = 1'b1;
        pcSel   = 2'b01;
        redirPc = newTarget;
        flushFd = 1'b1;
      end else begin
        pcWe = 1'b1;
      end
    end
  end

  // State, redirect buffer and handler flag; reset drops any parked redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      pend_q      <= 32'h0;
      pendValid_q <= 1'b0;
      inHandler_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
      inHandler_q <= inHandler_d;
    end
  end

  // Combinational outputs are forced idle while reset is held.
  assign bus.pc_we      = reset & pcWe;
  assign bus.pc_sel     = reset ? pcSel : 2'b00;
  assign bus.redir_pc   = reset ? redirPc : 32'h0;
  assign bus.flush_fd   = reset & flushFd;
  assign bus.pend_valid = pendValid_q;
  assign bus.in_handler = inHandler_q;

endmodule

// File: tb/tb_pc_redirect_arb.sv
// Self-checking bench for pc_redirect_arb: directed scenarios for each
// behaviour plus a randomized run against a queue-based reference model.
module tb_pc_redirect_arb;

  typedef struct packed {
    logic        eret;
    logic [31:0] epc;
    logic        intReq;
    logic        pause;
    logic        brTaken;
    logic [31:0] brTarget;
    logic        jrValid;
    logic        jrWait;
    logic [31:0] jrTarget;
  } stim_t;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

  pc_redirect_arb_if bus();

  pc_redirect_arb #(.EXC_VEC(32'h0000_4180)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Observed outputs packed as {pc_we, pc_sel, flush_fd, pend_valid, in_handler, redir_pc}.
  logic [37:0] obsVec;
  assign obsVec = {bus.pc_we, bus.pc_sel, bus.flush_fd, bus.pend_valid,
                   bus.in_handler, bus.redir_pc};

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Builds one stimulus record from individual fields.
  function automatic stim_t mkStim(input logic e, input logic [31:0] ep,
                                   input logic ir, input logic pa,
                                   input logic bt, input logic [31:0] btg,
                                   input logic jv, input logic jw,
                                   input logic [31:0] jt);
    stim_t s;
    s.eret = e; s.epc = ep; s.intReq = ir; s.pause = pa;
    s.brTaken = bt; s.brTarget = btg;
    s.jrValid = jv; s.jrWait = jw; s.jrTarget = jt;
    return s;
  endfunction

  // Builds one expected output vector in the obsVec layout.
  function automatic logic [37:0] mkExp(input logic we, input logic [1:0] sel,
                                        input logic fl, input logic pv,
                                        input logic ih, input logic [31:0] rd);
    return {we, sel, fl, pv, ih, rd};
  endfunction

  // Drives all request inputs of the interface.
  task automatic applyStimulus(input stim_t s);
    bus.eret      = s.eret;
    bus.epc       = s.epc;
    bus.int_req   = s.intReq;
    bus.pause     = s.pause;
    bus.br_taken  = s.brTaken;
    bus.br_target = s.brTarget;
    bus.jr_valid  = s.jrValid;
    bus.jr_wait   = s.jrWait;
    bus.jr_target = s.jrTarget;
  endtask

  // Moves to 1 ns after the next rising edge, where new inputs are driven.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs a table of cycles: drive, let logic settle, compare before the edge.
  task automatic runTable(input string name, input stim_t st[], input logic [37:0] ex[]);
    for (int i = 0; i < st.size(); i++) begin
      applyStimulus(st[i]);
      #3;
      testsRun++;
      if (obsVec !== ex[i]) begin
        testsFailed++;
        $display("[TB] FAIL %s step %0d: got %h expected %h", name, i, obsVec, ex[i]);
      end
      nextCycle();
    end
  endtask

  // Reset holds every output idle even with a branch on the inputs.
  task automatic test_reset();
    stim_t idle;
    idle = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(mkStim(0, 0, 1, 0, 1, 32'h3010, 0, 0, 0));
    #2;
    testsRun++;
    if (obsVec !== 38'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: got %h expected %h", obsVec, 38'h0);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (obsVec !== 38'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_held_edge: got %h expected %h", obsVec, 38'h0);
    end
    applyStimulus(idle);
    #2;
    reset = 1'b1;
    nextCycle();
  endtask

  // Unstalled taken branch redirects in the same cycle.
  task automatic test_branch();
    stim_t st[3];
    logic [37:0] ex[3];
    st[0] = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex[0] = mkExp(1, 2'b00, 0, 0, 0, 32'h0);
    st[1] = mkStim(0, 0, 0, 0, 1, 32'h3010, 0, 0, 0);
    ex[1] = mkExp(1, 2'b01, 1, 0, 0, 32'h3010);
    st[2] = mkStim(0, 0, 0, 0, 0, 32'h3010, 0, 0, 0);
    ex[2] = mkExp(1, 2'b00, 0, 0, 0, 32'h0);
    runTable("branch", st, ex);
  endtask

  // Two branches during a stall: the first is kept and replayed on release.
  task automatic test_stalled_redirect();
    stim_t st[5];
    logic [37:0] ex[5];
    st[0] = mkStim(0, 0, 0, 1, 1, 32'h3040, 0, 0, 0);
    ex[0] = mkExp(0, 2'b00, 0, 0, 0, 32'h0);
    st[1] = mkStim(0, 0, 0, 1, 1, 32'h3080, 0, 0, 0);
    ex[1] = mkExp(0, 2'b00, 0, 1, 0, 32'h0);
    st[2] = mkStim(0, 0, 0, 1, 0, 0, 0, 0, 0);
    ex[2] = mkExp(0, 2'b00, 0, 1, 0, 32'h0);
    st[3] = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex[3] = mkExp(1, 2'b01, 1, 1, 0, 32'h3040);
    st[4] = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex[4] = mkExp(1, 2'b00, 0, 0, 0, 32'h0);
    runTable("stalled_redirect", st, ex);
  endtask

  // jr waiting on forwarding holds the PC, then redirects and returns to RUN.
  task automatic test_jr_wait();
    stim_t st[4];
    logic [37:0] ex[4];
    st[0] = mkStim(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_0000);
    ex[0] = mkExp(0, 2'b00, 0, 0, 0, 32'h0);
    st[1] = mkStim(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_0004);
    ex[1] = mkExp(0, 2'b00, 0, 0, 0, 32'h0);
    st[2] = mkStim(0, 0, 0, 0, 0, 0, 1, 0, 32'h3100);
    ex[2] = mkExp(1, 2'b01, 1, 0, 0, 32'h3100);
    st[3] = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex[3] = mkExp(1, 2'b00, 0, 0, 0, 32'h0);
    runTable("jr_wait", st, ex);
  endtask

  // Interrupt discards a buffered redirect, nests are ignored, eret returns.
  task automatic test_interrupt();
    stim_t st[5];
    logic [37:0] ex[5];
    st[0] = mkStim(0, 0, 0, 1, 1, 32'h3200, 0, 0, 0);
    ex[0] = mkExp(0, 2'b00, 0, 0, 0, 32'h0);
    st[1] = mkStim(0, 0, 1, 1, 0, 0, 0, 0, 0);
    ex[1] = mkExp(1, 2'b10, 1, 1, 0, 32'h0);
    st[2] = mkStim(0, 0, 1, 0, 0, 0, 0, 0, 0);
    ex[2] = mkExp(1, 2'b00, 0, 0, 1, 32'h0);
    st[3] = mkStim(1, 32'h3024, 1, 0, 0, 0, 0, 0, 0);
    ex[3] = mkExp(1, 2'b11, 1, 0, 1, 32'h0);
    st[4] = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex[4] = mkExp(1, 2'b00, 0, 0, 0, 32'h0);
    runTable("interrupt", st, ex);
  endtask

  // eret wins over a simultaneous interrupt and branch.
  task automatic test_simultaneous();
    stim_t st[2];
    logic [37:0] ex[2];
    st[0] = mkStim(1, 32'h3024, 1, 0, 1, 32'h3500, 0, 0, 0);
    ex[0] = mkExp(1, 2'b11, 1, 0, 0, 32'h0);
    st[1] = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex[1] = mkExp(1, 2'b00, 0, 0, 0, 32'h0);
    runTable("simultaneous", st, ex);
  endtask

  // Reset pulse while waiting on jr with a parked redirect leaves no trace.
  task automatic test_reset_in_jrw();
    stim_t st[3];
    logic [37:0] ex[3];
    stim_t after[2];
    logic [37:0] exAfter[2];
    st[0] = mkStim(0, 0, 0, 0, 0, 0, 1, 1, 0);
    ex[0] = mkExp(0, 2'b00, 0, 0, 0, 32'h0);
    st[1] = mkStim(0, 0, 0, 1, 1, 32'h3300, 0, 0, 0);
    ex[1] = mkExp(0, 2'b00, 0, 0, 0, 32'h0);
    st[2] = mkStim(0, 0, 0, 1, 0, 0, 1, 1, 0);
    ex[2] = mkExp(0, 2'b00, 0, 1, 0, 32'h0);
    runTable("reset_in_jrw_setup", st, ex);
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    #1;
    testsRun++;
    if (obsVec !== 38'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_jrw_pulse: got %h expected %h", obsVec, 38'h0);
    end
    #2;
    reset = 1'b1;
    nextCycle();
    after[0] = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exAfter[0] = mkExp(1, 2'b00, 0, 0, 0, 32'h0);
    after[1] = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exAfter[1] = mkExp(1, 2'b00, 0, 0, 0, 32'h0);
    runTable("reset_in_jrw_after", after, exAfter);
  endtask

  // Random traffic against a reference model that tracks only a handler
  // flag, a queue of parked redirect targets and whether a jr is outstanding.
  task automatic test_random();
    logic        handler;
    logic        jrOut;
    logic [31:0] pendQ[$];
    stim_t       s;
    logic        we, fl, pvBefore, ihBefore, canRedir;
    logic [1:0]  sel;
    logic [31:0] rd, tgt;
    logic [37:0] exp;
    handler = 1'b0;
    jrOut   = 1'b0;
    pendQ.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 99) < 3) begin
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        #2;
        testsRun++;
        if (obsVec !== 38'h0) begin
          testsFailed++;
          $display("[TB] FAIL random_reset cycle %0d: got %h expected %h", cyc, obsVec, 38'h0);
        end
        #1;
        reset = 1'b1;
        handler = 1'b0;
        jrOut   = 1'b0;
        pendQ.delete();
        nextCycle();
        continue;
      end
      s.eret     = ($urandom_range(0, 19) == 0);
      s.epc      = $urandom;
      s.intReq   = ($urandom_range(0, 11) == 0);
      s.pause    = ($urandom_range(0, 2) == 0);
      s.brTaken  = ($urandom_range(0, 3) == 0);
      s.brTarget = $urandom;
      s.jrValid  = ($urandom_range(0, 4) == 0);
      s.jrWait   = ($urandom_range(0, 1) == 0);
      s.jrTarget = $urandom;
      applyStimulus(s);
      #3;

      pvBefore = (pendQ.size() != 0);
      ihBefore = handler;
      we = 1'b0; sel = 2'b00; fl = 1'b0; rd = 32'h0;
      canRedir = s.jrValid ? !s.jrWait : s.brTaken;
      tgt      = s.jrValid ? s.jrTarget : s.brTarget;
      if (s.eret) begin
        we = 1'b1; sel = 2'b11; fl = 1'b1;
        handler = 1'b0; jrOut = 1'b0; pendQ.delete();
      end else if (s.intReq && !handler) begin
        we = 1'b1; sel = 2'b10; fl = 1'b1;
        handler = 1'b1; jrOut = 1'b0; pendQ.delete();
      end else if (s.pause) begin
        if (canRedir && pendQ.size() == 0) pendQ.push_back(tgt);
      end else if (pendQ.size() != 0) begin
        we = 1'b1; sel = 2'b01; fl = 1'b1; rd = pendQ.pop_front();
        jrOut = 1'b0;
      end else if (jrOut) begin
        if (!s.jrWait) begin
          we = 1'b1; sel = 2'b01; fl = 1'b1; rd = s.jrTarget; jrOut = 1'b0;
        end
      end else if (s.jrValid && s.jrWait) begin
        jrOut = 1'b1;
      end else if (canRedir) begin
        we = 1'b1; sel = 2'b01; fl = 1'b1; rd = tgt;
      end else begin
        we = 1'b1;
      end
      exp = mkExp(we, sel, fl, pvBefore, ihBefore, rd);

      testsRun++;
      if (obsVec !== exp) begin
        testsFailed++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", cyc, obsVec, exp);
      end
      nextCycle();
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_branch();
    test_stalled_redirect();
    test_jr_wait();
    test_interrupt();
    test_simultaneous();
    test_reset_in_jrw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
